chnl_rx: RTL and testbench

Buffered Riffa/CHNL receiver: accepts host-to-FPGA transfers on one Riffa RX channel and delivers them as an o_val/o_rdy stream of RX_WIDTH-bit words. It is the receive-side counterpart of the channel transmitter and sits between the Riffa endpoint and the user datapath. Incoming PCIe beats are buffered in the shared `fifo` and width-converted by the shared `repacker`. Trailing words that do not form a whole CHNL_ALIGN group are consumed from the host and discarded.

---
 rtl/chnl_rx.sv | 227 ++++++++++++++++++++++
 tb/tb_chnl_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/chnl_rx.sv
// Riffa CHNL receive channel: accepts host transfers, buffers beats in a fifo and
// repacks them into RX_WIDTH-bit stream words; non-aligned tails are consumed and dropped.

module fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic         clk_i,
  input  logic         srst_i,
  input  logic         in_val,
  output logic         in_rdy,
  input  logic [W-1:0] in_data,
  output logic         out_val,
  input  logic         out_rdy,
  output logic [W-1:0] out_data
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  assign in_rdy   = (count != (AW+1)'(DEPTH));
  assign out_val  = (count != '0);
  assign out_data = mem[rd_ptr];
  assign push     = in_val & in_rdy;
  assign pop      = out_val & out_rdy;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= in_data;
  end
endmodule

module repacker #(
  parameter int IN  = 2,
  parameter int OUT = 1,
  parameter int W   = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_val,
  output logic            in_rdy,
  input  logic [IN*W-1:0] in_data,
  output logic            out_val,
  input  logic            out_rdy,
  output logic [OUT*W-1:0] out_data
);
  localparam int BUFN = IN + OUT;
  localparam int CW   = $clog2(BUFN + 1);

  // Word 0 of the holding buffer is always the oldest word.
  logic [BUFN*W-1:0] pk_q, pk_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_mid;
  logic              push, pop;

  assign in_rdy   = (cnt_q <= CW'(OUT));
  assign out_val  = (cnt_q >= CW'(OUT));
  assign out_data = pk_q[OUT*W-1:0];
  assign push     = in_val & in_rdy;
  assign pop      = out_val & out_rdy;

  always_comb begin
    pk_d    = pk_q;
    cnt_mid = cnt_q;
    if (pop) begin
      pk_d    = pk_q >> (OUT*W);
      cnt_mid = cnt_q - CW'(OUT);
    end
    cnt_d = cnt_mid;
    if (push) begin
      for (int i = 0; i < IN; i++) begin
        pk_d[(int'(cnt_mid) + i)*W +: W] = in_data[i*W +: W];
      end
      cnt_d = cnt_mid + CW'(IN);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  always_ff @(posedge clk_i) begin
    pk_q <= pk_d;
  end
endmodule

module chnl_rx #(
  parameter int C_PCI_DATA_WIDTH = 32,
  parameter int RX_WIDTH         = 32,
  parameter int GCD              = 32,
  parameter int CHNL_ALIGN       = 4,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  output logic                        o_val,
  input  logic                        o_rdy,
  output logic [RX_WIDTH-1:0]         o_data,
  output logic                        o_trunc,
  output logic                        CHNL_RX_CLK,
  input  logic                        CHNL_RX,
  output logic                        CHNL_RX_ACK,
  input  logic                        CHNL_RX_LAST,
  input  logic [31:0]                 CHNL_RX_LEN,
  input  logic [30:0]                 CHNL_RX_OFF,
  input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
  input  logic                        CHNL_RX_DATA_VALID,
  output logic                        CHNL_RX_DATA_REN
);
  localparam int WPB   = C_PCI_DATA_WIDTH / 32;
  localparam int ALIGN = CHNL_ALIGN / WPB;

  typedef enum logic [2:0] {S_IDLE, S_ACK, S_RECV, S_DRAIN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] fwd_q, fwd_d, total_q, total_d;
  logic [31:0] fwd_init, total_init;
  logic [32:0] len_round;
  logic        fifo_in_rdy, fifo_out_val, rp_in_rdy, xfer;
  logic [C_PCI_DATA_WIDTH-1:0] fifo_out_data;
  logic        unused_ok;

  assign unused_ok   = ^{CHNL_RX_LAST, CHNL_RX_OFF};
  assign CHNL_RX_CLK = clk_i;

  // Forwarded beats cover whole alignment groups; the rest of the length is drained.
  assign fwd_init   = (CHNL_RX_LEN / 32'(CHNL_ALIGN)) * 32'(ALIGN);
  assign len_round  = {1'b0, CHNL_RX_LEN} + 33'(WPB - 1);
  assign total_init = 32'(len_round / 33'(WPB));

  // REN follows fifo space directly so a full fifo never loses a beat.
  assign CHNL_RX_DATA_REN = (state_q == S_RECV) ? fifo_in_rdy : (state_q == S_DRAIN);
  assign xfer             = CHNL_RX_DATA_VALID & CHNL_RX_DATA_REN;

  always_comb begin
    state_d     = state_q;
    fwd_d       = fwd_q;
    total_d     = total_q;
    CHNL_RX_ACK = 1'b0;
    o_trunc     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (CHNL_RX) begin
          fwd_d   = fwd_init;
          total_d = total_init;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        CHNL_RX_ACK = 1'b1;
        o_trunc     = (total_q > fwd_q);
        if (fwd_q != '0)        state_d = S_RECV;
        else if (total_q != '0) state_d = S_DRAIN;
        else                    state_d = S_DONE;
      end
      S_RECV: begin
        if (xfer) begin
          fwd_d   = fwd_q - 1'b1;
          total_d = total_q - 1'b1;
          if (fwd_q == 32'd1) state_d = (total_q == 32'd1) ? S_DONE : S_DRAIN;
        end else if (!CHNL_RX) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (xfer) begin
          total_d = total_q - 1'b1;
          if (total_q == 32'd1) state_d = S_DONE;
        end else if (!CHNL_RX) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (!CHNL_RX) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      fwd_q   <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      fwd_q   <= fwd_d;
      total_q <= total_d;
    end
  end

  fifo #(.W(C_PCI_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i    (clk_i),
    .srst_i   (!rst_ni),
    .in_val   (xfer && (state_q == S_RECV)),
    .in_rdy   (fifo_in_rdy),
    .in_data  (CHNL_RX_DATA),
    .out_val  (fifo_out_val),
    .out_rdy  (rp_in_rdy),
    .out_data (fifo_out_data)
  );

  repacker #(.IN(C_PCI_DATA_WIDTH / GCD), .OUT(RX_WIDTH / GCD), .W(GCD)) u_repacker (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .in_val   (fifo_out_val),
    .in_rdy   (rp_in_rdy),
    .in_data  (fifo_out_data),
    .out_val  (o_val),
    .out_rdy  (o_rdy),
    .out_data (o_data)
  );
endmodule

// File: tb/tb_chnl_rx.sv
// Directed bench for chnl_rx with 64-bit beats, 32-bit output words and 4-word alignment.

module tb_chnl_rx;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        o_val, o_trunc, CHNL_RX_CLK, CHNL_RX_ACK, CHNL_RX_DATA_REN;
  logic        o_rdy = 1'b1;
  logic [31:0] o_data;
  logic        CHNL_RX = 1'b0;
  logic        CHNL_RX_LAST = 1'b0;
  logic [31:0] CHNL_RX_LEN = '0;
  logic [30:0] CHNL_RX_OFF = '0;
  logic [63:0] CHNL_RX_DATA = '0;
  logic        CHNL_RX_DATA_VALID = 1'b0;

  int checks = 0, failures = 0;
  int ack_cnt = 0, trunc_cnt = 0, trunc_ack = 0, ren_cnt = 0, xfer_cnt = 0;
  logic [31:0] outq[$];

  int  h_len, h_nbeats, h_abort, h_base;
  bit  h_kill = 1'b0;
  int  h_b = 0, h_done = 0;
  int  done_exp;
  event go;

  chnl_rx #(.C_PCI_DATA_WIDTH(64), .RX_WIDTH(32), .GCD(32), .CHNL_ALIGN(4)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .o_val              (o_val),
    .o_rdy              (o_rdy),
    .o_data             (o_data),
    .o_trunc            (o_trunc),
    .CHNL_RX_CLK        (CHNL_RX_CLK),
    .CHNL_RX            (CHNL_RX),
    .CHNL_RX_ACK        (CHNL_RX_ACK),
    .CHNL_RX_LAST       (CHNL_RX_LAST),
    .CHNL_RX_LEN        (CHNL_RX_LEN),
    .CHNL_RX_OFF        (CHNL_RX_OFF),
    .CHNL_RX_DATA       (CHNL_RX_DATA),
    .CHNL_RX_DATA_VALID (CHNL_RX_DATA_VALID),
    .CHNL_RX_DATA_REN   (CHNL_RX_DATA_REN)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (rst_ni) begin
      if (CHNL_RX_ACK) ack_cnt++;
      if (o_trunc) begin
        trunc_cnt++;
        if (CHNL_RX_ACK) trunc_ack++;
      end
      if (CHNL_RX_DATA_REN) ren_cnt++;
      if (CHNL_RX_DATA_REN && CHNL_RX_DATA_VALID) xfer_cnt++;
      if (o_val && o_rdy) outq.push_back(o_data);
    end
  end

  // Host model: offers beats back to back until done, aborted or killed.
  initial begin
    int cyc;
    bit take;
    forever begin
      @(go);
      h_b = 0;
      cyc = 0;
      @(negedge clk_i);
      CHNL_RX     = 1'b1;
      CHNL_RX_LEN = 32'(h_len);
      while (h_b < h_nbeats && h_b != h_abort && cyc < 8000 && !h_kill) begin
        CHNL_RX_DATA_VALID = 1'b1;
        CHNL_RX_DATA = {32'(h_base + 2*h_b + 1), 32'(h_base + 2*h_b)};
        #1 take = CHNL_RX_DATA_REN;
        @(posedge clk_i);
        if (!h_kill && take) h_b++;
        cyc++;
        @(negedge clk_i);
      end
      CHNL_RX_DATA_VALID = 1'b0;
      @(negedge clk_i);
      CHNL_RX = 1'b0;
      repeat (3) @(negedge clk_i);
      h_done++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input int len, input int nbeats, input int abort_at, input int base);
    h_len    = len;
    h_nbeats = nbeats;
    h_abort  = abort_at;
    h_base   = base;
    done_exp = h_done + 1;
    ->go;
    @(negedge clk_i);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 10000 && h_done != done_exp; i++) @(posedge clk_i);
    check(tag, 64'(h_done), 64'(done_exp));
  endtask

  task automatic check_words(input string tag, input int n0, input int base, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (n0 + i >= outq.size()) bad++;
      else if (outq[n0 + i] !== 32'(base + i)) bad++;
    end
    check(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    int a0, t0, ta0, r0, x0, n0;

    repeat (3) @(negedge clk_i);
    check("rst_ack", 64'(CHNL_RX_ACK), 64'd0);
    check("rst_ren", 64'(CHNL_RX_DATA_REN), 64'd0);
    check("rst_oval", 64'(o_val), 64'd0);
    check("rst_trunc", 64'(o_trunc), 64'd0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1 check("rx_clk", 64'(CHNL_RX_CLK), 64'(clk_i));

    // Basic aligned transfer
    a0 = ack_cnt; t0 = trunc_cnt; x0 = xfer_cnt; n0 = outq.size();
    start(8, 4, -1, 0);
    wait_done("basic_done");
    repeat (20) @(posedge clk_i);
    check("basic_ack", 64'(ack_cnt - a0), 64'd1);
    check("basic_trunc", 64'(trunc_cnt - t0), 64'd0);
    check("basic_xfer", 64'(xfer_cnt - x0), 64'd4);
    check("basic_nwords", 64'(outq.size() - n0), 64'd8);
    check_words("basic_words", n0, 0, 8);

    // Truncated tail: 5 beats consumed, 8 words out
    a0 = ack_cnt; t0 = trunc_cnt; ta0 = trunc_ack; x0 = xfer_cnt; n0 = outq.size();
    start(10, 5, -1, 0);
    wait_done("trunc_done");
    repeat (20) @(posedge clk_i);
    check("trunc_ack", 64'(ack_cnt - a0), 64'd1);
    check("trunc_pulse", 64'(trunc_cnt - t0), 64'd1);
    check("trunc_on_ack", 64'(trunc_ack - ta0), 64'd1);
    check("trunc_xfer", 64'(xfer_cnt - x0), 64'd5);
    check("trunc_nwords", 64'(outq.size() - n0), 64'd8);
    check_words("trunc_words", n0, 0, 8);

    // Zero length
    a0 = ack_cnt; t0 = trunc_cnt; r0 = ren_cnt; n0 = outq.size();
    start(0, 0, -1, 0);
    wait_done("zero_done");
    repeat (10) @(posedge clk_i);
    check("zero_ack", 64'(ack_cnt - a0), 64'd1);
    check("zero_ren", 64'(ren_cnt - r0), 64'd0);
    check("zero_trunc", 64'(trunc_cnt - t0), 64'd0);
    check("zero_nwords", 64'(outq.size() - n0), 64'd0);

    // Backpressure: 16-deep fifo plus one beat held in the repacker
    o_rdy = 1'b0;
    x0 = xfer_cnt; n0 = outq.size();
    start(2048, 1024, -1, 0);
    repeat (60) @(negedge clk_i);
    #1;
    check("bp_ren_low", 64'(CHNL_RX_DATA_REN), 64'd0);
    check("bp_valid_high", 64'(CHNL_RX_DATA_VALID), 64'd1);
    check("bp_xfer_full", 64'(xfer_cnt - x0), 64'd17);
    check("bp_oval_held", 64'(o_val), 64'd1);
    o_rdy = 1'b1;
    wait_done("bp_done");
    repeat (40) @(posedge clk_i);
    check("bp_xfer", 64'(xfer_cnt - x0), 64'd1024);
    check("bp_nwords", 64'(outq.size() - n0), 64'd2048);
    check_words("bp_words", n0, 0, 2048);

    // Host abort after 2 beats, then a normal transfer
    a0 = ack_cnt; n0 = outq.size();
    start(8, 4, 2, 0);
    wait_done("abort_done");
    repeat (20) @(posedge clk_i);
    check("abort_beats", 64'(h_b), 64'd2);
    check("abort_nwords", 64'(outq.size() - n0), 64'd4);
    check_words("abort_words", n0, 0, 4);
    a0 = ack_cnt; x0 = xfer_cnt; n0 = outq.size();
    start(4, 2, -1, 100);
    wait_done("after_abort_done");
    repeat (20) @(posedge clk_i);
    check("after_abort_ack", 64'(ack_cnt - a0), 64'd1);
    check("after_abort_xfer", 64'(xfer_cnt - x0), 64'd2);
    check("after_abort_nwords", 64'(outq.size() - n0), 64'd4);
    check_words("after_abort_words", n0, 100, 4);

    // Reset during the third beat
    start(8, 4, -1, 0);
    for (int i = 0; i < 2000 && h_b < 2; i++) #1;
    check("rst_mid_reach", 64'(h_b), 64'd2);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    h_kill = 1'b1;
    #1;
    check("rst_mid_ack", 64'(CHNL_RX_ACK), 64'd0);
    check("rst_mid_ren", 64'(CHNL_RX_DATA_REN), 64'd0);
    check("rst_mid_oval", 64'(o_val), 64'd0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    h_kill = 1'b0;
    n0 = outq.size();
    wait_done("rst_mid_done");
    repeat (40) @(posedge clk_i);
    check("rst_mid_residual", 64'(outq.size() - n0), 64'd0);
    a0 = ack_cnt; n0 = outq.size();
    start(8, 4, -1, 200);
    wait_done("rst_recover_done");
    repeat (20) @(posedge clk_i);
    check("rst_recover_ack", 64'(ack_cnt - a0), 64'd1);
    check("rst_recover_nwords", 64'(outq.size() - n0), 64'd8);
    check_words("rst_recover_words", n0, 200, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
